// File: rtl/rvfi_pkg.sv
// Shared RVFI retirement packet definition, used by the tile wrapper packing,
// the reorder buffer and the trace writer.
package rvfi_pkg;

    localparam int unsigned RVFI_XLEN   = 64;
    localparam int unsigned RVFI_ILEN   = 32;
    localparam int unsigned RVFI_MASK_W = RVFI_XLEN / 8;

    typedef struct packed {
        logic [RVFI_XLEN-1:0]   order;
        logic [RVFI_ILEN-1:0]   insn;
        logic                   trap;
        logic                   halt;
        logic                   intr;
        logic [1:0]             mode;
        logic [1:0]             ixl;
        logic [RVFI_XLEN-1:0]   pc_rdata;
        logic [RVFI_XLEN-1:0]   pc_wdata;
        logic [4:0]             rs1_addr;
        logic [RVFI_XLEN-1:0]   rs1_rdata;
        logic [4:0]             rs2_addr;
        logic [RVFI_XLEN-1:0]   rs2_rdata;
        logic [4:0]             rd_addr;
        logic [RVFI_XLEN-1:0]   rd_wdata;
        logic [RVFI_XLEN-1:0]   mem_addr;
        logic [RVFI_MASK_W-1:0] mem_rmask;
        logic [RVFI_MASK_W-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]   mem_rdata;
        logic [RVFI_XLEN-1:0]   mem_wdata;
    } rvfi_pkt_t;

endpackage

// File: rtl/rvfi_reorder_buf.sv
// Order-indexed reorder window that turns the non-monotonic RVFI retirement
// stream into a gap-free, strictly increasing stream with valid/ready output.
module rvfi_reorder_buf
    import rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  rvfi_pkt_t               in_pkt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output rvfi_pkt_t               out_pkt,
    output logic [RVFI_XLEN-1:0]    next_order,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_window,
    output logic                    err_dup
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = IDX_W + 1;

    logic [DEPTH-1:0]     slot_vld_q, slot_vld_d;
    rvfi_pkt_t            slot_pkt_q [DEPTH];
    rvfi_pkt_t            slot_pkt_d [DEPTH];
    logic                 out_valid_q, out_valid_d;
    rvfi_pkt_t            out_pkt_q, out_pkt_d;
    logic [RVFI_XLEN-1:0] next_order_q, next_order_d;
    logic [OCC_W-1:0]     occupancy_q, occupancy_d;
    logic                 err_window_q, err_window_d;
    logic                 err_dup_q, err_dup_d;

    logic [RVFI_XLEN-1:0] win_dist_c;
    logic [IDX_W-1:0]     wr_idx_c, rd_idx_c;
    logic                 in_win_c, wr_c, dup_c, drain_c;

    // Window/duplicate classification of the incoming packet and drain decision.
    always_comb begin
        win_dist_c = in_pkt.order - next_order_q;
        in_win_c   = win_dist_c < RVFI_XLEN'(DEPTH);
        wr_idx_c   = in_pkt.order[IDX_W-1:0];
        rd_idx_c   = next_order_q[IDX_W-1:0];
        dup_c      = in_valid && in_win_c && slot_vld_q[wr_idx_c];
        wr_c       = in_valid && in_win_c && !slot_vld_q[wr_idx_c];
        drain_c    = slot_vld_q[rd_idx_c] && (!out_valid_q || out_ready);
    end

    // Next-state; write and drain never hit the same slot, so both may apply.
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_pkt_d   = slot_pkt_q;
        out_valid_d  = out_valid_q;
        out_pkt_d    = out_pkt_q;
        next_order_d = next_order_q;
        err_window_d = err_window_q || (in_valid && !in_win_c);
        err_dup_d    = err_dup_q || dup_c;
        occupancy_d  = occupancy_q + OCC_W'(wr_c) - OCC_W'(drain_c);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (drain_c) begin
            out_valid_d          = 1'b1;
            out_pkt_d            = slot_pkt_q[rd_idx_c];
            slot_vld_d[rd_idx_c] = 1'b0;
            next_order_d         = next_order_q + RVFI_XLEN'(1);
        end
        if (wr_c) begin
            slot_vld_d[wr_idx_c] = 1'b1;
            slot_pkt_d[wr_idx_c] = in_pkt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_vld_q   <= '0;
            out_valid_q  <= 1'b0;
            out_pkt_q    <= '0;
            next_order_q <= '0;
            occupancy_q  <= '0;
            err_window_q <= 1'b0;
            err_dup_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_pkt_q[i] <= '0;
            end
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_pkt_q   <= slot_pkt_d;
            out_valid_q  <= out_valid_d;
            out_pkt_q    <= out_pkt_d;
            next_order_q <= next_order_d;
            occupancy_q  <= occupancy_d;
            err_window_q <= err_window_d;
            err_dup_q    <= err_dup_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pkt    = out_pkt_q;
    assign next_order = next_order_q;
    assign occupancy  = occupancy_q;
    assign err_window = err_window_q;
    assign err_dup    = err_dup_q;

endmodule

// File: tb/tb_rvfi_reorder_buf.sv
// Scoreboard bench for rvfi_reorder_buf: expected orders are queued as stimulus
// is driven and popped on every output transfer.
module tb_rvfi_reorder_buf;
    import rvfi_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    rvfi_pkt_t              in_pkt;
    logic                   out_valid;
    logic                   out_ready;
    rvfi_pkt_t              out_pkt;
    logic [63:0]            next_order;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   err_window;
    logic                   err_dup;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb [$];

    rvfi_reorder_buf #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pkt     (in_pkt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pkt    (out_pkt),
        .next_order (next_order),
        .occupancy  (occupancy),
        .err_window (err_window),
        .err_dup    (err_dup)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Deterministic packet contents derived from order; salt makes look-alike duplicates.
    function automatic rvfi_pkt_t mk(input logic [63:0] o, input logic [63:0] salt);
        rvfi_pkt_t p;
        p           = '0;
        p.order     = o;
        p.insn      = 32'(o * 64'd3 + salt) ^ 32'h0000_0013;
        p.trap      = o[0];
        p.mode      = o[2:1];
        p.pc_rdata  = (o << 2) + 64'h8000_0000;
        p.pc_wdata  = p.pc_rdata + 64'd4;
        p.rd_addr   = o[4:0];
        p.rd_wdata  = {o[31:0], ~o[31:0]} ^ salt;
        p.mem_wmask = o[7:0];
        p.mem_wdata = (o ^ 64'hA5A5_5A5A_0F0F_F0F0) + salt;
        return p;
    endfunction

    function automatic logic [63:0] fold(input rvfi_pkt_t p);
        logic [$bits(rvfi_pkt_t)-1:0] b;
        logic [63:0] f;
        b = p;
        f = '0;
        for (int i = 0; i < $bits(rvfi_pkt_t); i++) begin
            f = {f[62:0], f[63] ^ b[i]};
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [63:0] o, input logic [63:0] salt);
        in_valid = 1'b1;
        in_pkt   = mk(o, salt);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) begin
            step();
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: every transfer must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_pkt.order, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("out_order", out_pkt.order, e);
                chk("out_payload", fold(out_pkt), fold(mk(e, 64'd0)));
            end
        end
    end

    initial begin
        logic [63:0] ooo [3];
        int          peak;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pkt    = '0;
        out_ready = 1'b0;

        // Reset state
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pkt", fold(out_pkt), 64'd0);
        chk("rst_next_order", next_order, 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_errs", 64'({err_window, err_dup}), 64'd0);

        // In-order stream with two-cycle latency
        out_ready = 1'b1;
        sb.push_back(64'd0); sb.push_back(64'd1); sb.push_back(64'd2);
        in_valid = 1'b1;
        in_pkt   = mk(64'd0, 64'd0);
        step();
        chk("lat_occ_n", 64'(occupancy), 64'd1);
        chk("lat_valid_n", 64'(out_valid), 64'd0);
        in_pkt = mk(64'd1, 64'd0);
        step();
        chk("lat_valid_n1", 64'(out_valid), 64'd1);
        chk("lat_order_n1", out_pkt.order, 64'd0);
        chk("inord_occ1", 64'(occupancy), 64'd1);
        in_pkt = mk(64'd2, 64'd0);
        step();
        in_valid = 1'b0;
        chk("inord_order1", out_pkt.order, 64'd1);
        chk("inord_occ2", 64'(occupancy), 64'd1);
        step();
        chk("inord_order2", out_pkt.order, 64'd2);
        chk("inord_occ3", 64'(occupancy), 64'd0);
        step();
        chk("inord_idle", 64'(out_valid), 64'd0);
        chk("inord_next", next_order, 64'd3);
        chk("inord_errs", 64'({err_window, err_dup}), 64'd0);

        // Out-of-order 2,0,1
        do_reset();
        out_ready = 1'b1;
        ooo[0] = 64'd2; ooo[1] = 64'd0; ooo[2] = 64'd1;
        sb.push_back(64'd0); sb.push_back(64'd1); sb.push_back(64'd2);
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3);
            if (i < 3) in_pkt = mk(ooo[i], 64'd0);
            step();
            if (int'(occupancy) > peak) peak = int'(occupancy);
        end
        in_valid = 1'b0;
        wait_drain(10);
        chk("ooo_peak", 64'(peak), 64'd2);
        chk("ooo_next", next_order, 64'd3);
        chk("ooo_errs", 64'({err_window, err_dup}), 64'd0);

        // Duplicate order 0 under backpressure
        do_reset();
        out_ready = 1'b0;
        drive(64'd0, 64'd0);
        drive(64'd0, 64'd7);
        chk("dup_flag", 64'(err_dup), 64'd1);
        chk("dup_no_window", 64'(err_window), 64'd0);
        sb.push_back(64'd0);
        out_ready = 1'b1;
        wait_drain(10);
        step();
        step();
        chk("dup_single", 64'(out_valid), 64'd0);
        chk("dup_occ", 64'(occupancy), 64'd0);

        // Window, full buffer, duplicate while full, backpressure, drain
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int o = 1; o <= 8; o++) begin
            in_pkt = mk(64'(o), 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk("win_flag", 64'(err_window), 64'd1);
        chk("win_occ7", 64'(occupancy), 64'd7);
        chk("win_no_dup", 64'(err_dup), 64'd0);
        drive(64'd0, 64'd0);
        chk("full_occ8", 64'(occupancy), 64'd8);
        chk("full_no_out", 64'(out_valid), 64'd0);
        drive(64'd3, 64'd1);
        chk("full_dup", 64'(err_dup), 64'd1);
        chk("full_occ7", 64'(occupancy), 64'd7);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_order", out_pkt.order, 64'd0);
            chk("bp_payload", fold(out_pkt), fold(mk(64'd0, 64'd0)));
            step();
        end
        for (int o = 0; o < 8; o++) sb.push_back(64'(o));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 64'(out_valid), 64'd1);
            step();
        end
        chk("stream_done", 64'(out_valid), 64'd0);
        chk("stream_sb", 64'(sb.size()), 64'd0);
        chk("stream_next", next_order, 64'd8);
        chk("stream_occ", 64'(occupancy), 64'd0);

        // Wrap across 2^64-1 -> 0 with next_order preloaded
        do_reset();
        force dut.next_order_d = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        release dut.next_order_d;
        chk("wrap_preload", next_order, 64'hFFFF_FFFF_FFFF_FFFE);
        out_ready = 1'b1;
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        sb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        sb.push_back(64'd0);
        sb.push_back(64'd1);
        in_valid = 1'b1;
        in_pkt = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd0); step();
        in_pkt = mk(64'hFFFF_FFFF_FFFF_FFFE, 64'd0); step();
        in_pkt = mk(64'd0, 64'd0);                   step();
        in_pkt = mk(64'd1, 64'd0);                   step();
        in_valid = 1'b0;
        wait_drain(10);
        step();
        chk("wrap_next", next_order, 64'd2);
        chk("wrap_errs", 64'({err_window, err_dup}), 64'd0);

        // Reset mid-stream discards everything, including an unaccepted output
        do_reset();
        out_ready = 1'b0;
        drive(64'd0, 64'd0);
        drive(64'd1, 64'd0);
        drive(64'd2, 64'd0);
        drive(64'd100, 64'd0);
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        chk("mid_pre_err", 64'(err_window), 64'd1);
        reset = 1'b1;
        step();
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_out_pkt", fold(out_pkt), 64'd0);
        chk("mid_next", next_order, 64'd0);
        chk("mid_occ", 64'(occupancy), 64'd0);
        chk("mid_errs", 64'({err_window, err_dup}), 64'd0);
        reset = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("mid_discarded", 64'(out_valid), 64'd0);
        chk("mid_occ_after", 64'(occupancy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
